hpdcache_victim_srrip: RTL
==========================

Name: hpdcache_victim_srrip

Overview:
- Next-generation victim selector for set-associative HPDcache configurations.
- Replaces stateless random/PLRU choice with per-set Static Re-Reference Interval Prediction (SRRIP): one RRPV counter per way per set, held in flops.
- Selection is a multi-cycle valid/ready transaction with iterative aging.
- Sits between the miss handler (selection requests) and the cache controller (hit/refill updates).

Parameters:
SETS, 64, number of cache sets (power of 2, >=2)
WAYS, 4, associativity (2..16)
RRPV_W, 2, width of each re-reference counter; RRPV_MAX = 2^RRPV_W-1
SET_W, $clog2(SETS), set index width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
updt_i  in  1  policy update strobe
updt_set_i  in  SET_W  set of update
updt_way_i  in  WAYS  one-hot way of update
updt_hit_i  in  1  1=hit (RRPV:=0), 0=refill (RRPV:=RRPV_MAX-1)
sel_req_i  in  1  victim selection request
sel_ready_o  out  1  selector can accept request
sel_set_i  in  SET_W  set to select in
sel_dir_valid_i  in  WAYS  valid bits of set
sel_dir_dirty_i  in  WAYS  dirty bits of set
sel_dir_fetch_i  in  WAYS  ways with refill in flight (not eligible)
sel_valid_o  out  1  one-cycle result strobe
sel_way_o  out  WAYS  one-hot victim; all-zero when sel_none_o
sel_none_o  out  1  no eligible way (qualified by sel_valid_o)

Behaviour:
- Interface: clock is clk_i; reset is rst_i, synchronous, active-high. Both are fixed.
- On reset:
  - FSM enters INIT; init counter := 0.
  - sel_ready_o=0, sel_valid_o=0, sel_way_o=0, sel_none_o=0.
- INIT:
  - Writes RRPV_MAX to all ways of set[init counter], one set per cycle.
  - After set SETS-1 is written, moves to IDLE. INIT lasts exactly SETS cycles.
  - Updates are ignored during INIT.
- IDLE:
  - sel_ready_o=1.
  - On sel_req_i: capture set and the three masks; go to EVAL.
- EVAL (sel_ready_o=0). Candidates = ~fetch. Evaluated once per cycle using registered RRPV state, in priority order:
  1. No candidates: pulse sel_valid_o with sel_none_o=1 and sel_way_o=0; go to IDLE.
  2. Any candidate with valid=0: select the lowest-index such way.
  3. Else, any candidate with RRPV==RRPV_MAX: select the lowest-index such way.
  4. Else: increment RRPV of every way in the set (saturating at RRPV_MAX); stay in EVAL.
- On a selection (cases 2 or 3):
  - Pulse sel_valid_o for one cycle; sel_way_o is the one-hot victim; return to IDLE.
  - RRPV state is not changed by the selection itself; the caller issues a refill update later.
- Latency: the result is sel_valid_o in the cycle after acceptance, plus k aging cycles, where k <= RRPV_MAX.
- sel_ready_o rises again in the cycle after sel_valid_o. Back-to-back throughput is one request every 2+k cycles.
- sel_way_o and sel_none_o hold their value until the next result.
- Updates (IDLE/EVAL):
  - Applied in the cycle of updt_i.
  - Hit sets RRPV to 0; refill sets RRPV to RRPV_MAX-1.
  - A non-one-hot updt_way_i updates every flagged way.
- Simultaneous aging and update on the same set:
  - The updated way takes the update value.
  - All other ways age.
  - The next EVAL cycle sees the merged state.
- Mask stability: masks are captured at acceptance, so later directory changes are not seen mid-transaction.
- Reset in any state (including EVAL mid-aging) aborts the transaction with no sel_valid_o, and re-enters INIT.
- Arithmetic: RRPV increments saturate; there is no wrap from RRPV_MAX to 0.

Optional Feature:
HPDCACHE_VICTIM_SRRIP_CLEAN_FIRST_EN
- Defined: in case 3, if any RRPV_MAX candidate has dirty=0, the lowest-index clean one is chosen; otherwise the lowest-index dirty one. This reduces writebacks.
- Undefined: sel_dir_dirty_i is ignored (it is not captured), and the port remains present.

Test Plan:
- Init/reset:
  - Assert rst_i 1 cycle; SETS=64 -> sel_ready_o=0 for exactly 64 cycles, then 1.
  - Selecting set 5 with all-valid, fetch=0 -> way 0 after 1 cycle (all RRPV=3).
- Invalid priority: valid=4'b1011, fetch=0 -> sel_way_o=4'b0100 one cycle after accept, no aging.
- Aging:
  - Set 3 all ways hit-updated (RRPV=0); then select, valid=4'hF.
  - Expect 3 aging cycles, sel_valid_o on the 4th cycle after accept, sel_way_o=4'b0001.
  - Afterwards all RRPVs are 3.
- Fetch exclusion/none:
  - fetch=4'b1111 -> sel_valid_o with sel_none_o=1, sel_way_o=0.
  - fetch=4'b0001 with all RRPV=3 -> sel_way_o=4'b0010.
- Update-during-aging collision:
  - Set 2 all RRPV=0; hit update way 1 of set 2 on every EVAL cycle.
  - Expect way 1 is never selected; result is 4'b0001 after 3 aging cycles.
- Clean-first (macro defined):
  - All RRPV=3, dirty=4'b0011 -> sel_way_o=4'b0100.
  - Macro undefined -> 4'b0001.

Source files
------------

// File: rtl/hpdcache_victim_srrip.sv
// SRRIP victim selector: per-set RRPV flops and an INIT sweep of SETS cycles; optional HPDCACHE_VICTIM_SRRIP_CLEAN_FIRST_EN.
// Latency 1+k cycles (k <= RRPV_MAX aging steps); sel_ready_o is low from acceptance until the cycle after sel_valid_o.
module hpdcache_victim_srrip #(
  parameter int unsigned SETS   = 64,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned RRPV_W = 2,
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             updt_i,
  input  logic [SET_W-1:0] updt_set_i,
  input  logic [WAYS-1:0]  updt_way_i,
  input  logic             updt_hit_i,
  input  logic             sel_req_i,
  output logic             sel_ready_o,
  input  logic [SET_W-1:0] sel_set_i,
  input  logic [WAYS-1:0]  sel_dir_valid_i,
  input  logic [WAYS-1:0]  sel_dir_dirty_i,
  input  logic [WAYS-1:0]  sel_dir_fetch_i,
  output logic             sel_valid_o,
  output logic [WAYS-1:0]  sel_way_o,
  output logic             sel_none_o
);

  localparam logic [RRPV_W-1:0] RRPV_MAX    = '1;
  localparam logic [RRPV_W-1:0] RRPV_REFILL = RRPV_MAX - RRPV_W'(1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_EVAL
  } state_e;

  state_e            state_q, state_d;
  logic [SET_W-1:0]  init_cnt_q, init_cnt_d;
  logic [SET_W-1:0]  set_q;
  logic [WAYS-1:0]   valid_q;
  logic [WAYS-1:0]   fetch_q;
  logic [WAYS-1:0]   way_q;
  logic              none_q;
  logic [RRPV_W-1:0] rrpv_q [SETS][WAYS];

  logic              capture;
  logic              age;
  logic              ready;
  logic              res_vld;
  logic [WAYS-1:0]   res_way;
  logic              res_none;
  logic [WAYS-1:0]   cand;
  logic [WAYS-1:0]   inval;
  logic [WAYS-1:0]   at_max;
  logic [WAYS-1:0]   max_pick;

  function automatic logic [WAYS-1:0] lowest_one(input logic [WAYS-1:0] m);
    return m & (~m + WAYS'(1));
  endfunction

`ifdef HPDCACHE_VICTIM_SRRIP_CLEAN_FIRST_EN
  logic [WAYS-1:0] dirty_q;
  logic [WAYS-1:0] clean_max;
`else
  logic unused_dirty;
  assign unused_dirty = ^sel_dir_dirty_i;
`endif

  // Candidate classification for the captured set, from registered RRPV state only.
  always_comb begin
    cand   = ~fetch_q;
    inval  = cand & ~valid_q;
    at_max = '0;
    for (int w = 0; w < WAYS; w++) begin
      at_max[w] = cand[w] && (rrpv_q[set_q][w] == RRPV_MAX);
    end
`ifdef HPDCACHE_VICTIM_SRRIP_CLEAN_FIRST_EN
    clean_max = at_max & ~dirty_q;
    max_pick  = (|clean_max) ? clean_max : at_max;
`else
    max_pick  = at_max;
`endif
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    capture    = 1'b0;
    age        = 1'b0;
    ready      = 1'b0;
    res_vld    = 1'b0;
    res_way    = '0;
    res_none   = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + SET_W'(1);
        if (init_cnt_q == SET_W'(SETS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (sel_req_i) begin
          capture = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (cand == '0) begin
          res_vld  = 1'b1;
          res_none = 1'b1;
          state_d  = ST_IDLE;
        end else if (|inval) begin
          res_vld = 1'b1;
          res_way = lowest_one(inval);
          state_d = ST_IDLE;
        end else if (|max_pick) begin
          res_vld = 1'b1;
          res_way = lowest_one(max_pick);
          state_d = ST_IDLE;
        end else begin
          age = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign sel_ready_o = ready;
  assign sel_valid_o = res_vld;
  assign sel_way_o   = res_vld ? res_way : way_q;
  assign sel_none_o  = res_vld ? res_none : none_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      way_q      <= '0;
      none_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      if (res_vld) begin
        way_q  <= res_way;
        none_q <= res_none;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      set_q   <= sel_set_i;
      valid_q <= sel_dir_valid_i;
      fetch_q <= sel_dir_fetch_i;
`ifdef HPDCACHE_VICTIM_SRRIP_CLEAN_FIRST_EN
      dirty_q <= sel_dir_dirty_i;
`endif
    end
  end

  // Update is written after aging so a colliding way takes the update value.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        rrpv_q[init_cnt_q][w] <= RRPV_MAX;
      end
    end else if (!rst_i) begin
      if (age) begin
        for (int w = 0; w < WAYS; w++) begin
          if (rrpv_q[set_q][w] != RRPV_MAX) begin
            rrpv_q[set_q][w] <= rrpv_q[set_q][w] + RRPV_W'(1);
          end
        end
      end
      if (updt_i) begin
        for (int w = 0; w < WAYS; w++) begin
          if (updt_way_i[w]) begin
            rrpv_q[updt_set_i][w] <= updt_hit_i ? '0 : RRPV_REFILL;
          end
        end
      end
    end
  end

endmodule
